// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet source and the router:
// FSM encoding, packet field positions and the packet formatter.
package noc_pkg;

   localparam int PKT_W       = 13;
   localparam int DEST_LSB    = 0;
   localparam int IDX_LSB     = 2;
   localparam int PAYLOAD_LSB = 4;
   localparam int PARITY_BIT  = 12;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      GAP_WAIT = 2'd2,
      DONE     = 2'd3
   } state_t;

   // The payload is base + index modulo 256; bit 12 makes the whole packet even parity.
   function automatic logic [PKT_W-1:0] noc_pkt_format(input logic [1:0] dest,
                                                       input logic [1:0] idx,
                                                       input logic [7:0] base);
      logic [PKT_W-1:0] pkt;
      pkt = '0;
      pkt[DEST_LSB +: 2]    = dest;
      pkt[IDX_LSB +: 2]     = idx;
      pkt[PAYLOAD_LSB +: 8] = base + {6'd0, idx};
      pkt[PARITY_BIT]       = ^pkt[PARITY_BIT-1:0];
      return pkt;
   endfunction

endpackage

// File: rtl/noc_packet_gen.sv
// Burst packet source: latches a command, emits formatted packets on a
// valid/ready/last handshake with an optional idle gap, then pulses done.
//
// Handshake: a packet transfers on any rising edge where valid && ready.
// Once valid is high, packet and last hold stable and valid stays high
// until that transfer happens (only reset may drop it early).
module noc_packet_gen
   import noc_pkg::*;
#(
   parameter int WIDTH_PACKET = 13,
   parameter int MAX_BURST    = 4,
   parameter int GAP          = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [1:0]              dest,
   input  logic [2:0]              burst_len,
   input  logic [7:0]              base_payload,
   input  logic                    ready,
   output logic                    valid,
   output logic                    last,
   output logic [WIDTH_PACKET-1:0] packet,
   output logic                    busy,
   output logic                    done,
   output state_t                  dbg_state
);

   state_t            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [2:0]        len_q, len_d;
   logic [1:0]        dest_q, dest_d;
   logic [7:0]        base_q, base_d;
   logic [7:0]        gap_cnt_q, gap_cnt_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic [PKT_W-1:0]  packet_q, packet_d;
   logic              done_q, done_d;

   logic [2:0]        eff_len;
   logic [1:0]        idx_inc;

   assign eff_len = (burst_len > 3'(MAX_BURST)) ? 3'(MAX_BURST) : burst_len;
   assign idx_inc = idx_q + 2'd1;

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         len_q     <= '0;
         dest_q    <= '0;
         base_q    <= '0;
         gap_cnt_q <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         packet_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         dest_q    <= dest_d;
         base_q    <= base_d;
         gap_cnt_q <= gap_cnt_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         packet_q  <= packet_d;
         done_q    <= done_d;
      end
   end

   // Next state plus the next value of every registered output; valid, last,
   // packet and done default low so packet is zero whenever valid is low.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      dest_d    = dest_q;
      base_d    = base_q;
      gap_cnt_d = gap_cnt_q;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      packet_d  = '0;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start && (eff_len != 3'd0)) begin
               state_d  = SEND;
               idx_d    = 2'd0;
               len_d    = eff_len;
               dest_d   = dest;
               base_d   = base_payload;
               valid_d  = 1'b1;
               last_d   = (eff_len == 3'd1);
               packet_d = noc_pkt_format(dest, 2'd0, base_payload);
            end
         end

         SEND: begin
            if (valid_q && ready) begin
               if (last_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (GAP > 0) begin
                  state_d   = GAP_WAIT;
                  gap_cnt_d = 8'(GAP - 1);
               end else begin
                  idx_d    = idx_inc;
                  valid_d  = 1'b1;
                  last_d   = ({1'b0, idx_inc} == (len_q - 3'd1));
                  packet_d = noc_pkt_format(dest_q, idx_inc, base_q);
               end
            end else begin
               // Stalled: hold the offered packet unchanged.
               valid_d  = valid_q;
               last_d   = last_q;
               packet_d = packet_q;
            end
         end

         GAP_WAIT: begin
            if (gap_cnt_q == 8'd0) begin
               state_d  = SEND;
               idx_d    = idx_inc;
               valid_d  = 1'b1;
               last_d   = ({1'b0, idx_inc} == (len_q - 3'd1));
               packet_d = noc_pkt_format(dest_q, idx_inc, base_q);
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign valid     = valid_q;
   assign last      = last_q;
   assign packet    = WIDTH_PACKET'(packet_q);
   assign done      = done_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_noc_packet_gen.sv
// Directed bench for noc_packet_gen: one instance with GAP=0 and one with GAP=2.
module tb_noc_packet_gen;
   import noc_pkg::*;

   logic        clk;
   logic        rst;
   logic        start0, start2;
   logic [1:0]  dest;
   logic [2:0]  burst_len;
   logic [7:0]  base_payload;
   logic        ready;

   logic        valid0, last0, busy0, done0;
   logic [12:0] packet0;
   state_t      st0;
   logic        valid2, last2, busy2, done2;
   logic [12:0] packet2;
   state_t      st2;

   int n_cmp = 0;
   int n_err = 0;

   noc_packet_gen #(.WIDTH_PACKET(13), .MAX_BURST(4), .GAP(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .dest(dest), .burst_len(burst_len),
      .base_payload(base_payload), .ready(ready), .valid(valid0), .last(last0),
      .packet(packet0), .busy(busy0), .done(done0), .dbg_state(st0)
   );

   noc_packet_gen #(.WIDTH_PACKET(13), .MAX_BURST(4), .GAP(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .dest(dest), .burst_len(burst_len),
      .base_payload(base_payload), .ready(ready), .valid(valid2), .last(last2),
      .packet(packet2), .busy(busy2), .done(done2), .dbg_state(st2)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Observed {valid,last,busy,done} and packet of the GAP=0 instance.
   task automatic chk0(input string tag, input logic [3:0] flags, input logic [12:0] pkt);
      chk({tag, ".flags"}, {28'd0, valid0, last0, busy0, done0}, {28'd0, flags});
      chk({tag, ".pkt"}, {19'd0, packet0}, {19'd0, pkt});
   endtask

   task automatic chk2(input string tag, input logic [3:0] flags, input logic [12:0] pkt);
      chk({tag, ".flags"}, {28'd0, valid2, last2, busy2, done2}, {28'd0, flags});
      chk({tag, ".pkt"}, {19'd0, packet2}, {19'd0, pkt});
   endtask

   task automatic cmd(input logic [1:0] d, input logic [2:0] l, input logic [7:0] b);
      dest = d;
      burst_len = l;
      base_payload = b;
   endtask

   // Flag encoding below: {valid, last, busy, done}.
   initial begin
      rst = 1'b1;
      start0 = 1'b0;
      start2 = 1'b0;
      ready = 1'b1;
      cmd(2'd0, 3'd0, 8'd0);
      step();
      step();
      chk0("reset0", 4'b0000, 13'h0000);
      chk2("reset2", 4'b0000, 13'h0000);
      chk("reset_state", {30'd0, st0}, {30'd0, IDLE});
      rst = 1'b0;
      step();

      // Basic burst, back-to-back.
      cmd(2'd1, 3'd3, 8'h10);
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      chk0("basic.p0", 4'b1010, 13'h0101);
      step();
      chk0("basic.p1", 4'b1010, 13'h0115);
      step();
      chk0("basic.p2", 4'b1110, 13'h0129);
      step();
      chk0("basic.done", 4'b0011, 13'h0000);
      step();
      chk0("basic.idle", 4'b0000, 13'h0000);

      // Same command, 4-cycle stall on the second packet.
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      chk0("stall.p0", 4'b1010, 13'h0101);
      step();
      chk0("stall.p1", 4'b1010, 13'h0115);
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk0($sformatf("stall.hold%0d", i), 4'b1010, 13'h0115);
      end
      ready = 1'b1;
      step();
      chk0("stall.p2", 4'b1110, 13'h0129);
      step();
      chk0("stall.done", 4'b0011, 13'h0000);
      step();

      // burst_len=7 clamps to 4.
      cmd(2'd0, 3'd7, 8'h20);
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      chk0("clamp.p0", 4'b1010, 13'h1200);
      step();
      chk0("clamp.p1", 4'b1010, 13'h1214);
      step();
      chk0("clamp.p2", 4'b1010, 13'h1228);
      step();
      chk0("clamp.p3", 4'b1110, 13'h123C);
      step();
      chk0("clamp.done", 4'b0011, 13'h0000);
      step();

      // burst_len=0 is ignored.
      cmd(2'd1, 3'd0, 8'h10);
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      chk0("zero.c1", 4'b0000, 13'h0000);
      step();
      chk0("zero.c2", 4'b0000, 13'h0000);

      // Payload wrap and odd parity data.
      cmd(2'd3, 3'd3, 8'hFE);
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      chk0("wrap.p0", 4'b1010, 13'h1FE3);
      step();
      chk0("wrap.p1", 4'b1010, 13'h1FF7);
      step();
      chk0("wrap.p2", 4'b1110, 13'h100B);
      step();
      chk0("wrap.done", 4'b0011, 13'h0000);
      step();

      // GAP=2 instance, with a stray start mid-burst.
      cmd(2'd1, 3'd2, 8'h10);
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      chk2("gap.p0", 4'b1010, 13'h0101);
      step();
      chk2("gap.w0", 4'b0010, 13'h0000);
      cmd(2'd2, 3'd4, 8'h77);
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      chk2("gap.w1", 4'b0010, 13'h0000);
      step();
      chk2("gap.p1", 4'b1110, 13'h0115);
      step();
      chk2("gap.done", 4'b0011, 13'h0000);
      step();
      chk2("gap.idle", 4'b0000, 13'h0000);

      // Reset during the second packet, then a clean single-packet burst.
      cmd(2'd1, 3'd3, 8'h10);
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      chk0("rst.p0", 4'b1010, 13'h0101);
      step();
      chk0("rst.p1", 4'b1010, 13'h0115);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk0("rst.after", 4'b0000, 13'h0000);
      step();
      chk0("rst.nodone", 4'b0000, 13'h0000);
      cmd(2'd2, 3'd1, 8'h55);
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      chk0("single.p0", 4'b1110, 13'h1552);
      step();
      chk0("single.done", 4'b0011, 13'h0000);
      step();
      chk0("single.idle", 4'b0000, 13'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/noc_packet_gen.md
# noc_packet_gen

Upstream packet source for the NoC router. It accepts a burst command (destination, length, base payload) and emits a sequence of 13-bit packets on a valid/ready/last handshake, stalling whenever the router deasserts `ready`. It asserts `last` on the final packet of each burst so the router can drain its FIFO and route. Packets can optionally be separated by a programmable idle gap.

## Interface
- `WIDTH_PACKET`, 13: packet width; fixed at 13 by the packet format.
- `MAX_BURST`, 4: maximum packets per burst; must be ≤ 4 because the index field is 2 bits.
- `GAP`, 0: idle cycles inserted between accepted packets; 0 means back-to-back.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle burst command strobe; sampled only in IDLE.
- `dest` input 2: destination port, placed in packet[1:0].
- `burst_len` input 3: number of packets requested.
- `base_payload` input 8: payload of packet 0.
- `ready` input 1: router can accept a packet.
- `valid` output 1: `packet` is valid.
- `last` output 1: the current packet is the final packet of the burst.
- `packet` output WIDTH_PACKET: formatted packet.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the final packet is accepted.

## Operation
Packet format:
- [1:0] = dest
- [3:2] = packet index i (0-based)
- [11:4] = base_payload + i, modulo 256 (wraps 0xFF→0x00)
- [12] = ^packet[11:0] (even parity over the whole packet)

Command capture:
- On `start` in IDLE, `dest`, `base_payload` and the effective length are latched.
- Effective length is min(`burst_len`, MAX_BURST).
- `burst_len` = 0: the command is ignored. The block stays in IDLE, with no `busy` and no `done`.
- `start` outside IDLE is ignored. Inputs are not re-sampled mid-burst.

State machine:
- IDLE: `start` with nonzero length → SEND; index is cleared.
- SEND: `valid`=1. On handshake (`valid` && `ready`):
  - if this is the last packet → DONE;
  - else if GAP>0 → GAP_WAIT, with the counter loaded to GAP−1;
  - else the index increments and the block stays in SEND.
- GAP_WAIT: `valid`=0. The counter decrements; at 0 the index increments and the block returns to SEND.
- DONE: `done`=1 for one cycle → IDLE.

Rules:
- `last` = `valid` && (index == effective length − 1).
- `packet`, `valid` and `last` are registered outputs.
- While `valid` && !`ready`, `packet` and `last` hold stable. `valid` never drops without a handshake.
- `packet` is zero whenever `valid`=0.

## Timing
- Reset values: `valid`, `last`, `busy` and `done` are 0, `packet` is 0, state is IDLE, and all counters are 0.
- `rst` asserted mid-burst takes effect at the next edge: `valid` drops with no handshake, and `done` is not pulsed. The router sees an unterminated burst. This is acceptable and documented.
- Latency from `start` to first `valid`: 1 cycle.
- Throughput: one packet per cycle with GAP=0 and `ready` held high. Otherwise one packet per GAP+1 cycles.
- `done` asserts the cycle after the final handshake.
- The earliest next `start` is accepted in the cycle after `done` (back in IDLE).
- A `ready` stall of any length is tolerated. A stall does not advance the gap counter.
- A single-packet burst drives `valid` and `last` together on the same cycle.

## Structure
- Shared package `noc_pkg` holds:
  - `state_t` (IDLE, SEND, GAP_WAIT, DONE);
  - field position constants (DEST_LSB=0, IDX_LSB=2, PAYLOAD_LSB=4, PARITY_BIT=12);
  - the packet width constant.
  The router uses the same field constants.
- No sub-module. Packet formatting and parity are a small combinational function in `noc_pkg` (`noc_pkt_format`), shared with the verification scoreboard.

## Test plan
- `dest`=01, `burst_len`=3, `base_payload`=0x10, GAP=0, `ready`=1 → packets 0x101, 0x115, 0x129 on three consecutive cycles; `last` only on 0x129; `done` one cycle later.
- Same command with `ready` low for 4 cycles on the second packet → 0x115 is held stable and `valid` stays high throughout; the total sequence is unchanged.
- `burst_len`=7 → clamped to 4 packets with indices 0–3; `last` on index 3. `burst_len`=0 → `busy` never rises.
- `base_payload`=0xFE, `burst_len`=3 → payloads 0xFE, 0xFF, 0x00 (wrap); parity is correct on each packet.
- GAP=2, `burst_len`=2 → exactly 2 cycles of `valid`=0 between handshakes; a `start` pulsed mid-burst has no effect.
- `rst` asserted during the second packet → next edge `valid`=0, `busy`=0, no `done`; a new `start` after reset runs a clean burst from index 0.
